// File: rtl/mips_loader_pkg.sv
// Shared types and default widths for the instruction-memory boot loader.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StHold = 2'd2,
    StRun  = 2'd3
  } state_e;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 5;

endpackage

// File: rtl/ins_mem_loader_if.sv
// Instruction stream in, instruction-memory write port out.
interface ins_mem_loader_if
  import mips_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              InsWrEN;
  logic [ADDR_W-1:0] InsWrAddr;
  logic [DATA_W-1:0] InsDataIn;

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output InsWrEN,
    output InsWrAddr,
    output InsDataIn
  );

  // Stream source / memory side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  InsWrEN,
    input  InsWrAddr,
    input  InsDataIn
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Boot loader: streams words into instruction memory, holds the CPU in reset
// while loading plus a settle time, then releases it.
module ins_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nRST,
  ins_mem_loader_if.slave   bus,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              cpu_nRST,
  output logic              cpu_nclear,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SpanW = ADDR_W + 2;
  localparam logic [SpanW-1:0] Depth = SpanW'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              range_err_q, range_err_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [SpanW-1:0]  range_end;
  logic              range_bad;

  // Request end address, wide enough that base + count never overflows.
  assign range_end = {2'b00, base_addr} + {1'b0, word_count};
  assign range_bad = range_end > Depth;

  // State register and registered datapath.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      range_err_q <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      range_err_q <= range_err_d;
      checksum_q  <= checksum_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    range_err_d = range_err_q;
    checksum_d  = checksum_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (start) begin
          if (range_bad) begin
            // Rejected request leaves a running CPU alone.
            range_err_d = 1'b1;
          end else begin
            range_err_d = 1'b0;
            checksum_d  = '0;
            ptr_d       = base_addr;
            remaining_d = word_count;
            hold_d      = '0;
            state_d     = (word_count == '0) ? StHold : StLoad;
          end
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = ptr_q;
          wr_data_d   = bus.in_data;
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          checksum_d  = checksum_q + bus.in_data;
          if (remaining_q == (ADDR_W + 1)'(1)) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
      end
      StHold: begin
        // Stays HOLD_CYCLES + 1 cycles so release lands HOLD_CYCLES + 1 edges after entry.
        if (hold_q == HoldW'(HOLD_CYCLES)) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status and handshake outputs are pure decodes of the state register.
  always_comb begin
    bus.in_ready = (state_q == StLoad);
    busy         = (state_q == StLoad) || (state_q == StHold);
    done         = (state_q == StRun);
    cpu_nRST     = (state_q == StRun);
    cpu_nclear   = (state_q == StRun);
  end

  assign bus.InsWrEN   = wr_en_q;
  assign bus.InsWrAddr = wr_addr_q;
  assign bus.InsDataIn = wr_data_q;
  assign range_err     = range_err_q;
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader with a write scoreboard.
module tb_ins_mem_loader;
  localparam int unsigned HoldCycles = 2;

  logic        clk;
  logic        nRST;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  word_count;
  logic        cpu_nRST;
  logic        cpu_nclear;
  logic        busy;
  logic        done;
  logic        range_err;
  logic [31:0] checksum;

  ins_mem_loader_if bus ();

  ins_mem_loader #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .HOLD_CYCLES (HoldCycles)
  ) dut (
    .clk        (clk),
    .nRST       (nRST),
    .bus        (bus.slave),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .cpu_nRST   (cpu_nRST),
    .cpu_nclear (cpu_nclear),
    .busy       (busy),
    .done       (done),
    .range_err  (range_err),
    .checksum   (checksum)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned wr_count = 0;
  logic [36:0] exp_q[$];
  logic [31:0] fixed_q[$];
  logic [31:0] exp_sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every write seen on the memory port must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.InsWrEN === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("write_addr_data", {27'd0, bus.InsWrAddr, bus.InsDataIn}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_wren"}, bus.InsWrEN, 1'b0);
    chk({tag, "_wraddr"}, bus.InsWrAddr, 5'd0);
    chk({tag, "_wrdata"}, bus.InsDataIn, 32'd0);
    chk({tag, "_cpu_nrst"}, cpu_nRST, 1'b0);
    chk({tag, "_cpu_nclear"}, cpu_nclear, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_range_err"}, range_err, 1'b0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  task automatic do_start(input logic [4:0] b, input logic [5:0] c);
    start = 1'b1;
    base_addr = b;
    word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [4:0] b, input bit gaps);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        bus.in_valid = 1'b0;
        tick();
        chk("gap_in_ready", bus.in_ready, 1'b1);
        chk("gap_no_write", bus.InsWrEN, 1'b0);
      end
      if (fixed_q.size() > 0) d = fixed_q.pop_front();
      else d = $urandom;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      chk("load_in_ready", bus.in_ready, 1'b1);
      exp_q.push_back({b + 5'(i), d});
      exp_sum = exp_sum + d;
      tick();
      chk("wr_latency_en", bus.InsWrEN, 1'b1);
      chk("wr_latency_addr", bus.InsWrAddr, b + 5'(i));
    end
    bus.in_valid = 1'b0;
  endtask

  // Called just after the last accept (or the start of an empty load).
  task automatic check_release(input string tag);
    for (int i = 1; i <= HoldCycles + 1; i++) begin
      tick();
      chk({tag, "_cpu_nrst"}, cpu_nRST, (i == HoldCycles + 1));
      chk({tag, "_cpu_nclear"}, cpu_nclear, (i == HoldCycles + 1));
      chk({tag, "_done"}, done, (i == HoldCycles + 1));
      chk({tag, "_busy"}, busy, (i != HoldCycles + 1));
      chk({tag, "_hold_ready"}, bus.in_ready, 1'b0);
    end
  endtask

  initial begin
    nRST = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    exp_sum = '0;
    #2;
    check_reset_vals("reset");
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Contiguous 13-word load at 1..13.
    do_start(5'd1, 6'd13);
    exp_sum = '0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_cpu_nrst", cpu_nRST, 1'b0);
    send_words(13, 5'd1, 1'b0);
    chk("t1_checksum", checksum, exp_sum);
    check_release("t1_rel");

    // Reload from RUN with gaps in the stream.
    do_start(5'd1, 6'd4);
    exp_sum = '0;
    chk("t2_done_fall", done, 1'b0);
    chk("t2_cpu_nrst_fall", cpu_nRST, 1'b0);
    chk("t2_checksum_clr", checksum, 32'd0);
    send_words(4, 5'd1, 1'b1);
    chk("t2_checksum", checksum, exp_sum);
    check_release("t2_rel");

    // Out-of-range start in RUN keeps the CPU running.
    do_start(5'd31, 6'd2);
    chk("t3_run_range_err", range_err, 1'b1);
    chk("t3_run_done", done, 1'b1);
    chk("t3_run_cpu_nrst", cpu_nRST, 1'b1);

    // Out-of-range start from IDLE.
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    tick();
    wr_count = 0;
    do_start(5'd30, 6'd3);
    chk("t4_range_err", range_err, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    tick();
    tick();
    chk("t4_cpu_nrst", cpu_nRST, 1'b0);
    chk("t4_no_writes", wr_count, 0);
    // Exactly fills the top of memory.
    do_start(5'd29, 6'd3);
    exp_sum = '0;
    chk("t4_range_clear", range_err, 1'b0);
    chk("t4_busy_ok", busy, 1'b1);
    send_words(3, 5'd29, 1'b0);
    check_release("t4_rel");

    // Reload of 2 words from RUN; checksum wraps.
    do_start(5'd5, 6'd2);
    exp_sum = '0;
    chk("t5_done_fall", done, 1'b0);
    chk("t5_cpu_nrst_fall", cpu_nRST, 1'b0);
    fixed_q.push_back(32'hFFFF_FFFF);
    fixed_q.push_back(32'h0000_0002);
    send_words(2, 5'd5, 1'b0);
    chk("t5_checksum_wrap", checksum, 32'h0000_0001);
    check_release("t5_rel");

    // Empty load goes straight to HOLD.
    wr_count = 0;
    do_start(5'd0, 6'd0);
    chk("t6_busy", busy, 1'b1);
    chk("t6_in_ready", bus.in_ready, 1'b0);
    check_release("t6_rel");
    chk("t6_no_writes", wr_count, 0);

    // Asynchronous reset in the middle of a load, then a full reload.
    do_start(5'd0, 6'd8);
    exp_sum = '0;
    send_words(3, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    nRST = 1'b0;
    #1;
    check_reset_vals("t7_midreset");
    tick();
    nRST = 1'b1;
    tick();
    do_start(5'd0, 6'd8);
    exp_sum = '0;
    send_words(8, 5'd0, 1'b0);
    chk("t7_checksum", checksum, exp_sum);
    check_release("t7_rel");

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ins_mem_loader.md
# ins_mem_loader

Parametrised instruction-memory boot loader for the MIPS CPU. Accepts instruction words over a valid/ready stream and writes them into CPU instruction memory through the InsWrEN/InsWrAddr/InsDataIn write port, from a programmable base address. Holds the CPU in reset (nRST/nclear low) during loading and for a programmable settle time, then releases it. Supports reload from RUN and reports a running checksum plus a range error.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 5, instruction-memory address width (depth 2^ADDR_W)
- HOLD_CYCLES, 2, cycles CPU reset stays asserted after the last write (≥1)
- clk  in  1  single clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled in IDLE and RUN only
- base_addr  in  ADDR_W  first write address, latched on accepted start
- word_count  in  ADDR_W+1  words to load (0..2^ADDR_W), latched on accepted start
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream instruction word
- in_ready  out  1  loader accepts a word this cycle
- InsWrEN  out  1  instruction-memory write enable, one cycle per word
- InsWrAddr  out  ADDR_W  write address
- InsDataIn  out  DATA_W  write data
- cpu_nRST  out  1  CPU register-file reset, active-low
- cpu_nclear  out  1  CPU PC clear, active-low
- busy  out  1  state is LOAD or HOLD
- done  out  1  state is RUN
- range_err  out  1  sticky; last start rejected for out-of-range request
- checksum  out  DATA_W  sum mod 2^DATA_W of words written in the current load

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- Reset values: state IDLE; in_ready 0; InsWrEN 0; InsWrAddr 0; InsDataIn 0; cpu_nRST 0; cpu_nclear 0; busy 0; done 0; range_err 0; checksum 0.
- IDLE or RUN with start=1:
  - If base_addr + word_count > 2^ADDR_W (width ADDR_W+2 compare): range_err←1. State unchanged, so a CPU in RUN keeps running.
  - Otherwise: range_err←0, checksum←0, latch base and count, drive cpu_nRST/cpu_nclear to 0 next cycle. Go to LOAD, or to HOLD if word_count=0.
- LOAD: in_ready=1. Each cycle with in_valid&in_ready: write address = base + accepted index; remaining−1; checksum += in_data. On the final word go to HOLD. Address never wraps (guaranteed by the range check).
- HOLD: in_ready=0; counter counts HOLD_CYCLES cycles, then RUN.
- RUN: cpu_nRST=cpu_nclear=1, done=1. A new valid start reasserts CPU reset and reloads.
- start is ignored in LOAD and HOLD. in_valid outside LOAD is ignored and not consumed.
- nRST asserted mid-load: immediate return to reset values. Partially written memory is left as is.

## Timing
- in_ready is a decode of the state register only. It has no combinational path from in_valid.
- Write latency is 1: a word accepted at edge k drives InsWrEN=1 with its address and data for the cycle after edge k. InsWr* outputs are registered.
- Throughput is one word per cycle. Back-to-back valid gives contiguous InsWrEN pulses.
- Last word accepted at edge k: state becomes HOLD at k. cpu_nRST/cpu_nclear rise at edge k+HOLD_CYCLES+1, the same edge at which done rises.
- word_count=0: start at edge k, then HOLD, then release at edge k+HOLD_CYCLES+1.
- checksum updates at the same edge as the acceptance.
- Accepted start in RUN: cpu_nRST falls at the next edge, the same edge at which done falls.

## Structure
- Shared package mips_loader_pkg: state enum (IDLE, LOAD, HOLD, RUN) and default width constants DATA_W=32, ADDR_W=5.
- No sub-module. The hold counter is $clog2(HOLD_CYCLES+1) bits inline.

## Test plan
- Reset, then start with base=1, count=13, one word per cycle → 13 InsWrEN pulses at addr 1..13 with the stream data. cpu_nRST rises 3 edges after the last accept (HOLD_CYCLES=2). done=1.
- Stream gaps: in_valid toggling 1,0,1,0 with count=4 → exactly 4 writes, addresses 1..4 contiguous. in_ready stays 1 throughout LOAD.
- Range: base=30, count=3 (ADDR_W=5) → range_err=1, state IDLE, no writes, cpu_nRST stays 0. Then base=29, count=3 → loads addr 29..31, range_err clears.
- Reload from RUN: second start with count=2 → cpu_nRST low the next edge, done=0, 2 writes. checksum equals the sum of the 2 new words only.
- Checksum wrap: words 0xFFFFFFFF and 0x00000002 → checksum 0x00000001.
- nRST pulse after 3 of 8 words → all outputs at reset values, in_ready=0. A fresh start reloads from the beginning.
